// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between fetch reads and data loads/stores.
// Optional fetch anti-starvation streak limit enabled by defining MEM_ARB_FAIRNESS_EN.
//
// state   | meaning
// S_IDLE  | no access in flight; arbitrate pending requests
// S_FETCH | instruction read issued, waiting for i_mem_ready
// S_DATA  | load/store issued, waiting for i_mem_ready
// S_RESP  | ack pulse to the owner; forced bubble before next grant
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_f_req,
  input  logic [ADDR_W-1:0] i_f_addr,
  output logic              o_f_ack,
  output logic [DATA_W-1:0] o_f_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic              i_d_byte,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic              o_mem_byte,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_grant_d;
  logic              w_grant_f;
  logic              w_fetch_priority;
  logic              r_owner_d;
  logic              r_we;
  logic              r_byte;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [DATA_W-1:0] w_byte_data;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  logic [STREAK_W-1:0] r_streak;

  assign w_fetch_priority = i_f_req && (r_streak == STREAK_W'(MAX_D_STREAK));

  // Streak counts only data grants that actually made a waiting fetch wait.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_streak <= '0;
    else if (w_grant_f) r_streak <= '0;
    else if (w_grant_d) r_streak <= i_f_req ? r_streak + 1'b1 : '0;
  end
`else
  assign w_fetch_priority = 1'b0;
`endif

  assign w_grant_d = (r_state == S_IDLE) && i_d_req && !w_fetch_priority;
  assign w_grant_f = (r_state == S_IDLE) && i_f_req && !w_grant_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d)      w_next = S_DATA;
        else if (w_grant_f) w_next = S_FETCH;
      end
      S_FETCH, S_DATA: if (i_mem_ready) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_byte_data = {{(DATA_W-8){1'b0}}, i_mem_rdata[8*r_addr[1:0] +: 8]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_byte    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant_d) begin
        r_owner_d <= 1'b1;
        r_we      <= i_d_we;
        r_byte    <= i_d_byte;
        r_addr    <= i_d_addr;
        r_wdata   <= i_d_wdata;
      end else if (w_grant_f) begin
        r_owner_d <= 1'b0;
        r_we      <= 1'b0;
        r_byte    <= 1'b0;
        r_addr    <= i_f_addr;
        r_wdata   <= '0;
      end
      if (r_state == S_FETCH && i_mem_ready) r_f_rdata <= i_mem_rdata;
      // Stores complete without touching the load data register.
      if (r_state == S_DATA && i_mem_ready && !r_we)
        r_d_rdata <= r_byte ? w_byte_data : i_mem_rdata;
    end
  end

  assign o_mem_req   = (r_state == S_FETCH) || (r_state == S_DATA);
  assign o_mem_we    = (r_state == S_DATA) && r_we;
  assign o_mem_byte  = (r_state == S_DATA) && r_byte;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_f_ack     = (r_state == S_RESP) && !r_owner_d;
  assign o_d_ack     = (r_state == S_RESP) && r_owner_d;
  assign o_f_rdata   = r_f_rdata;
  assign o_d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; grant-order expectations follow MEM_ARB_FAIRNESS_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, f_ack;
  logic [31:0] f_addr, f_rdata;
  logic        d_req, d_we, d_byte, d_ack;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_byte, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_ack(f_ack), .o_f_rdata(f_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_byte(d_byte), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .o_d_ack(d_ack), .o_d_rdata(d_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_byte(mem_byte),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_d;
    rst_n = 1'b0; f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_byte = 0;
    d_addr = 0; d_wdata = 0; mem_ready = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_acks", {30'b0, f_ack, d_ack}, 32'd0);
    chk("rst_rdata", f_rdata | d_rdata, 32'd0);

    // 1: reset during a data access abandons it
    rst_n = 1'b1;
    d_req = 1; d_we = 0; d_addr = 32'h10;
    tick();
    chk("t1_mem_req_data", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0; d_req = 0;
    #1;
    chk("t1_async_mem_req", {31'b0, mem_req}, 32'd0);
    chk("t1_async_d_ack", {31'b0, d_ack}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_no_ack", {30'b0, f_ack, d_ack}, 32'd0);
      chk("t1_idle", {31'b0, mem_req}, 32'd0);
    end
    mem_ready = 0;

    // 2: fetch with one wait state
    f_req = 1; f_addr = 32'h40;
    tick();
    chk("t2_c1_mem_req", {31'b0, mem_req}, 32'd1);
    chk("t2_c1_mem_we", {31'b0, mem_we}, 32'd0);
    chk("t2_c1_mem_addr", mem_addr, 32'h40);
    chk("t2_c1_f_ack", {31'b0, f_ack}, 32'd0);
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("t2_resp_f_ack", {31'b0, f_ack}, 32'd1);
    chk("t2_resp_d_ack", {31'b0, d_ack}, 32'd0);
    chk("t2_f_rdata", f_rdata, 32'hDEADBEEF);
    chk("t2_resp_mem_req", {31'b0, mem_req}, 32'd0);
    f_req = 0; mem_ready = 0; mem_rdata = 32'h0;
    tick();
    chk("t2_ack_pulse", {31'b0, f_ack}, 32'd0);
    chk("t2_f_rdata_hold", f_rdata, 32'hDEADBEEF);

    // 3: simultaneous requests, data store first, then fetch after a bubble
    f_req = 1; f_addr = 32'h80;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h12345678;
    mem_ready = 1; mem_rdata = 32'h55555555;
    tick();
    chk("t3_store_mem_we", {31'b0, mem_we}, 32'd1);
    chk("t3_store_addr", mem_addr, 32'h100);
    chk("t3_store_wdata", mem_wdata, 32'h12345678);
    tick();
    chk("t3_d_ack", {30'b0, f_ack, d_ack}, 32'd1);
    chk("t3_d_rdata_unchanged", d_rdata, 32'd0);
    d_req = 0; d_we = 0;
    tick();
    chk("t3_bubble", {31'b0, mem_req}, 32'd0);
    mem_rdata = 32'h0BADF00D;
    tick();
    chk("t3_fetch_req", {31'b0, mem_req}, 32'd1);
    chk("t3_fetch_we", {31'b0, mem_we}, 32'd0);
    chk("t3_fetch_addr", mem_addr, 32'h80);
    tick();
    chk("t3_f_ack", {30'b0, f_ack, d_ack}, 32'd2);
    chk("t3_f_rdata", f_rdata, 32'h0BADF00D);
    f_req = 0;
    tick();
    chk("t3_ready_ignored_idle", {30'b0, f_ack, d_ack}, 32'd0);

    // 4: byte load selects lane 3, then word load
    d_req = 1; d_byte = 1; d_addr = 32'h203; mem_rdata = 32'hAABBCCDD;
    tick();
    chk("t4_mem_byte", {31'b0, mem_byte}, 32'd1);
    chk("t4_mem_addr", mem_addr, 32'h203);
    tick();
    chk("t4_d_ack", {31'b0, d_ack}, 32'd1);
    chk("t4_byte_rdata", d_rdata, 32'h000000AA);
    d_byte = 0; d_addr = 32'h204; mem_rdata = 32'h11223344;
    tick();
    tick();
    chk("t4_word_mem_byte", {31'b0, mem_byte}, 32'd0);
    tick();
    chk("t4_word_rdata", d_rdata, 32'h11223344);
    d_req = 0;
    tick();

    // 5: both requests held; grant order depends on fairness build
    d_req = 1; d_addr = 32'h300; f_req = 1; f_addr = 32'h500;
    for (int g = 0; g < 6; g++) begin
`ifdef MEM_ARB_FAIRNESS_EN
      exp_d = (g != 4);
`else
      exp_d = 1'b1;
`endif
      tick();
      chk($sformatf("t5_grant%0d_addr", g), mem_addr, exp_d ? 32'h300 : 32'h500);
      tick();
      chk($sformatf("t5_grant%0d_ack", g), {30'b0, f_ack, d_ack}, exp_d ? 32'd1 : 32'd2);
      tick();
      chk($sformatf("t5_grant%0d_bubble", g), {31'b0, mem_req}, 32'd0);
    end
    d_req = 0; f_req = 0;
    tick(); tick(); tick();

    // 6: alternating single requesters with mem_ready stuck high
    for (int n = 0; n < 4; n++) begin
      exp_d = n[0];
      d_req = exp_d; f_req = !exp_d;
      tick();
      chk($sformatf("t6_%0d_c1_noack", n), {30'b0, f_ack, d_ack}, 32'd0);
      tick();
      chk($sformatf("t6_%0d_ack", n), {30'b0, f_ack, d_ack}, exp_d ? 32'd1 : 32'd2);
      d_req = 0; f_req = 0;
      tick();
      chk($sformatf("t6_%0d_idle", n), {29'b0, mem_req, f_ack, d_ack}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
